// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback request, register-file write port, issue reservation
// and hazard query signals shared by the arbiter and whatever drives it.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int N_REGS  = 32,
  parameter int R_WIDTH = 32
);
  localparam int W_ADDR = $clog2(N_REGS);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*W_ADDR-1:0]  req_addr;
  logic [N_REQ*R_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     wb_stall;

  logic                     wr_en;
  logic [W_ADDR-1:0]        wr_addr;
  logic [R_WIDTH-1:0]       wr_data;

  logic                     iss_valid;
  logic [W_ADDR-1:0]        iss_addr;
  logic                     iss_ready;

  logic [W_ADDR-1:0]        rs1_addr;
  logic [W_ADDR-1:0]        rs2_addr;
  logic                     rs1_busy;
  logic                     rs2_busy;

  modport slave (
    input  req_valid, req_addr, req_data, wb_stall,
    input  iss_valid, iss_addr, rs1_addr, rs2_addr,
    output req_ready, wr_en, wr_addr, wr_data,
    output iss_ready, rs1_busy, rs2_busy
  );

  modport master (
    output req_valid, req_addr, req_data, wb_stall,
    output iss_valid, iss_addr, rs1_addr, rs2_addr,
    input  req_ready, wr_en, wr_addr, wr_data,
    input  iss_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file, with a busy scoreboard
// that blocks WAW reservations and answers RAW hazard queries.
module regfile_wb_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_REGS  = 32,
  parameter int R_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int W_ADDR = $clog2(N_REGS);
  localparam int W_PTR  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [W_PTR-1:0]   ptr;
  logic [N_REGS-1:0]  busy;
  logic [N_REGS-1:0]  busy_nxt;
  logic               grant_any;
  logic [W_PTR-1:0]   grant_idx;
  logic [W_ADDR-1:0]  win_addr;
  logic [R_WIDTH-1:0] win_data;
  logic               win_wr;
  logic               iss_ok;
  logic               wr_en_q;
  logic [W_ADDR-1:0]  wr_addr_q;
  logic [R_WIDTH-1:0] wr_data_q;

  function automatic logic in_range(input logic [W_ADDR-1:0] a);
    return int'(a) < N_REGS;
  endfunction

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin : grant_pick
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!rst && !bus.wb_stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = (int'(ptr) + k) % N_REQ;
        if (!grant_any && bus.req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = W_PTR'(cand);
        end
      end
    end
  end

  assign bus.req_ready = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  assign win_addr      = bus.req_addr[int'(grant_idx)*W_ADDR +: W_ADDR];
  assign win_data      = bus.req_data[int'(grant_idx)*R_WIDTH +: R_WIDTH];
  assign win_wr        = grant_any && (win_addr != '0) && in_range(win_addr);

  // A writeback retiring the same register this cycle frees it for a new reservation.
  assign iss_ok = !rst &&
                  ((bus.iss_addr == '0) ||
                   !(in_range(bus.iss_addr) && busy[bus.iss_addr]) ||
                   (win_wr && (win_addr == bus.iss_addr)));

  assign bus.iss_ready = iss_ok;
  assign bus.rs1_busy  = in_range(bus.rs1_addr) && busy[bus.rs1_addr];
  assign bus.rs2_busy  = in_range(bus.rs2_addr) && busy[bus.rs2_addr];

  // Clear before set so a simultaneous reservation of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (win_wr) begin
      busy_nxt[win_addr] = 1'b0;
    end
    if (bus.iss_valid && iss_ok && (bus.iss_addr != '0) && in_range(bus.iss_addr)) begin
      busy_nxt[bus.iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      busy      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy    <= busy_nxt;
      wr_en_q <= win_wr;
      if (grant_any) begin
        ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + W_PTR'(1);
      end
      if (win_wr) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of writeback requesters (ALU, LSU, MUL/DIV, FPU-to-int).
REQ-002 SHALL have parameter N_REGS, default 32, meaning the number of architectural registers.
REQ-003 SHALL have parameter R_WIDTH, default 32, meaning the register data width.
REQ-004 SHALL have localparam W_ADDR = $clog2(N_REGS), meaning the register address width.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  requester i holds a writeback.
REQ-008 req_addr  in  N_REQ*W_ADDR  destination of requester i (slice i).
REQ-009 req_data  in  N_REQ*R_WIDTH  data of requester i (slice i).
REQ-010 req_ready  out  N_REQ  one-hot grant, combinational; transfer when valid&ready.
REQ-011 wb_stall  in  1  blocks all grants this cycle.
REQ-012 wr_en / wr_addr / wr_data  out  1/W_ADDR/R_WIDTH  registered drive of the register-file write port.
REQ-013 iss_valid, iss_addr  in  1, W_ADDR  decode reserves a destination register.
REQ-014 iss_ready  out  1  reservation accepted this cycle.
REQ-015 rs1_addr, rs2_addr  in  W_ADDR each  hazard query addresses.
REQ-016 rs1_busy, rs2_busy  out  1 each  queried register has a pending write (combinational).

Function
REQ-017 SHALL hold a round-robin pointer ptr (0..N_REQ-1); priority order ptr, ptr+1, ..., wrapping modulo N_REQ.
REQ-018 SHALL assert at most one req_ready bit per cycle: the highest-priority valid requester, only when wb_stall=0.
REQ-019 After a grant to i, ptr SHALL become (i+1) mod N_REQ next cycle; no grant leaves ptr unchanged.
REQ-020 Grant SHALL register {wr_en=1, wr_addr, wr_data} of the winner on the next posedge (1-cycle latency); otherwise wr_en=0 and wr_addr/wr_data hold.
REQ-021 A grant with address 0 SHALL be accepted (ready=1) but produce wr_en=0.
REQ-022 SHALL keep a busy vector of N_REGS bits; bit 0 always 0.
REQ-023 iss_ready SHALL equal 1 when iss_addr==0 or busy[iss_addr]==0 (WAW block); iss_valid&iss_ready sets busy[iss_addr] next cycle (except address 0).
REQ-024 A granted writeback SHALL clear busy[addr] at the same posedge it registers wr_en.
REQ-025 Simultaneous set and clear of the same register SHALL leave it set.
REQ-026 rs1_busy/rs2_busy SHALL be busy[rsX_addr] combinationally, with no bypass of same-cycle grants.
REQ-027 Addresses >= N_REGS SHALL never set busy, SHALL return busy=0, and SHALL produce wr_en=0 when granted.
REQ-028 req_valid deasserting without a grant SHALL be tolerated; no state changes.

Reset
REQ-029 On rst=1 SHALL clear ptr=0, busy=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-030 During rst, req_ready SHALL be 0 and iss_ready SHALL be 0.
REQ-031 Reset mid-operation SHALL discard in-flight reservations; no wr_en pulse in the cycle after rst falls.

Verification
REQ-032 All four requesters valid for 4 cycles, addrs 1..4, ptr=0 -> grants 0,1,2,3 in order; wr_addr 1,2,3,4 one cycle after each grant.
REQ-033 Issue x5 -> rs1_addr=5 gives busy=1; a second issue of x5 gives iss_ready=0; writeback x5 data 0xDEADBEEF -> wr_en=1, wr_data=0xDEADBEEF, busy clears the next cycle.
REQ-034 Issue x7 and a grant for x7 in the same cycle with x7 already busy -> busy[7] stays 1.
REQ-035 Requester 2 writes x0 with 0x1234 -> req_ready[2]=1, wr_en=0, ptr advances to 3.
REQ-036 wb_stall=1 with requesters 1 and 3 valid -> no ready; release with ptr=2 -> requester 3 granted first, then 1.
REQ-037 rst asserted with busy={x3,x9} and requester 0 valid -> next cycle busy=0, wr_en=0, ptr=0.
